// File: rtl/jtbubl_romslot_pkg.sv
// Shared types and widths for the graphics ROM slot.
// Only the SDRAM-facing widths are fixed here; the graphics-side address width is a module parameter.
package jtbubl_romslot_pkg;

  localparam int SDRAM_AW = 22;
  localparam int SDRAM_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/jtbubl_gfx_romslot.sv
// Graphics ROM responder with a two-entry word cache in front of one SDRAM read port.
// Hits answer combinationally; a miss issues a single request/ack/rdy fetch and fills the victim entry.
module jtbubl_gfx_romslot
  import jtbubl_romslot_pkg::*;
#(
  parameter logic [SDRAM_AW-1:0] OFFSET = 22'h0,
  parameter int                  AW     = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rom_cs,
  input  logic [AW-1:0]       rom_addr,
  output logic [SDRAM_DW-1:0] rom_data,
  output logic                rom_ok,
  output logic                sdram_req,
  output logic [SDRAM_AW-1:0] sdram_addr,
  input  logic                sdram_ack,
  input  logic                sdram_rdy,
  input  logic [SDRAM_DW-1:0] sdram_din
);

  fsm_state_t          state;
  logic [1:0]          valid;
  logic [AW-1:0]       tag  [2];
  logic [SDRAM_DW-1:0] data [2];
  logic                victim;
  logic [AW-1:0]       fetch_addr;

  logic [1:0]          hit;
  logic                any_hit;
  logic                hit_idx;
  logic                fill;
  logic [SDRAM_AW-1:0] req_addr;

  assign hit[0]  = valid[0] & (tag[0] == rom_addr);
  assign hit[1]  = valid[1] & (tag[1] == rom_addr);
  assign any_hit = |hit;
  assign hit_idx = hit[1];

  assign rom_ok   = rom_cs & any_hit;
  assign rom_data = hit[1] ? data[1] : data[0];

  assign fill     = (state == ST_WAIT) & sdram_rdy;
  assign req_addr = OFFSET + SDRAM_AW'(rom_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      valid      <= 2'b00;
      victim     <= 1'b0;
      fetch_addr <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      for (int i = 0; i < 2; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      // A fill outranks a same-cycle hit so the freshly fetched word becomes most recent.
      if (fill) begin
        victim <= ~victim;
      end else if (rom_ok) begin
        victim <= ~hit_idx;
      end

      unique case (state)
        ST_IDLE: begin
          if (rom_cs && !any_hit) begin
            fetch_addr <= rom_addr;
            sdram_addr <= req_addr;
            sdram_req  <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sdram_rdy) begin
            data[victim]  <= sdram_din;
            tag[victim]   <= fetch_addr;
            valid[victim] <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/jtbubl_gfx_romslot.md
# jtbubl_gfx_romslot

Responder side of the graphics ROM request interface: serves the `rom_cs` / `rom_addr` / `rom_data` / `rom_ok` requests issued by the graphics engine. Data is fetched from SDRAM through a request/ack/ready handshake. A two-entry tag cache avoids repeated SDRAM accesses when the tile/object fetcher re-reads the same 32-bit word. The block sits between `jtbubl_gfx` and the SDRAM controller port assigned to graphics.

## Interface
Parameters:
- `OFFSET`, 22'h0, SDRAM word address of graphics ROM word 0.
- `AW`, 18, graphics-side word address width.

Ports:
- `clk`  in  1  system clock (48 MHz); one clock; every register is updated on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `rom_cs`  in  1  graphics engine requests the word at `rom_addr`.
- `rom_addr`  in  AW  requested word address.
- `rom_data`  out  32  word at `rom_addr`; valid while `rom_ok`.
- `rom_ok`  out  1  `rom_data` matches the current `rom_addr`.
- `sdram_req`  out  1  fetch request, held until acknowledged.
- `sdram_addr`  out  22  SDRAM word address, stable while `sdram_req` is high.
- `sdram_ack`  in  1  controller accepted the request (one-cycle pulse).
- `sdram_rdy`  in  1  `sdram_din` is valid this cycle (one-cycle pulse).
- `sdram_din`  in  32  read data from SDRAM.

## Operation
- Cache state per entry i ∈ {0,1}: `valid[i]`, `tag[i]` (AW bits), `data[i]` (32 bits). A one-bit `victim` pointer selects the entry to replace.
- Hit rule: `hit[i] = valid[i] & (tag[i] == rom_addr)`.
  - `rom_ok = rom_cs & (hit[0] | hit[1])`, combinational from the registered tags.
  - `rom_data = hit[1] ? data[1] : data[0]`.
  - The fill policy never lets both entries hold the same tag.
- Victim update:
  - On a cycle with `rom_ok` high, `victim <= ~hit_index`.
  - On a fill of entry i, `victim <= ~i`.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: if `rom_cs & ~hit`, latch `fetch_addr <= rom_addr`, drive `sdram_addr <= OFFSET + rom_addr` (22-bit sum, modulo 2^22) and `sdram_req <= 1`, then go to REQ.
  - REQ: hold `sdram_req` and `sdram_addr`. When `sdram_ack` is seen, `sdram_req <= 0` and go to WAIT.
  - WAIT: when `sdram_rdy` is seen, write `data[victim] <= sdram_din`, `tag[victim] <= fetch_addr`, `valid[victim] <= 1`, then go to IDLE.
- `sdram_rdy` is ignored in IDLE and in REQ.
- If `rom_addr` changes or `rom_cs` drops during REQ/WAIT, the fetch still completes and fills with `fetch_addr`. The block then re-evaluates in IDLE. `rom_ok` stays low until the tag matches the current address.
- Only one outstanding SDRAM request at a time.

## Timing
- Reset values:
  - `rom_ok` = 0; `rom_data` = 0.
  - `sdram_req` = 0; `sdram_addr` = 0.
  - FSM = IDLE; `valid` = 2'b00; `data` = 0; `victim` = 0.
- Reset mid-fetch: the block returns to IDLE next edge with the cache invalidated. A late `sdram_rdy` arriving afterwards is ignored.
- Hit latency: 0 cycles. `rom_ok` rises in the same cycle `rom_addr` presents a cached word.
- Miss latency: `sdram_req` rises 1 cycle after the miss. `rom_ok` rises 1 cycle after the `sdram_rdy` edge. Total = 2 + ack delay + rdy delay cycles.
- `sdram_ack` and `sdram_rdy` in the same cycle while in REQ: the ack is taken and the rdy is ignored. The controller guarantees rdy arrives at least one cycle after ack.
- Address change: `rom_ok` falls combinationally in the same cycle `rom_addr` moves to an uncached word. A stale `rom_ok` with mismatched data is never produced.

## Structure
- Shared package `jtbubl_romslot_pkg` holds:
  - FSM state enum (IDLE, REQ, WAIT);
  - constants for the SDRAM address width (22) and data width (32).
- Single module; no sub-module. The two cache entries are small enough to inline as arrays.

## Test plan
- Reset, then `rom_cs=1`, `rom_addr=18'h00010`, OFFSET=22'h080000:
  - `sdram_req` rises 1 cycle later with `sdram_addr=22'h080010`;
  - ack after 3 cycles, rdy with 32'hDEADBEEF 4 cycles later;
  - then `rom_ok=1`, `rom_data=32'hDEADBEEF`.
- Alternate `rom_addr` between 18'h00010 and 18'h00011 after both are filled: `rom_ok` is high every cycle and no further `sdram_req` is issued.
- Third address 18'h00012 after hitting 18'h00011 last: the new word replaces entry holding 18'h00010. A subsequent request for 18'h00010 misses.
- Change `rom_addr` to 18'h00020 while in WAIT for 18'h00012:
  - the 18'h00012 fill completes with `rom_ok` low;
  - a new request for 18'h00020 is issued the cycle after returning to IDLE.
- Assert `rst_n=0` for one cycle during WAIT, then pulse `sdram_rdy`:
  - `valid` is cleared, `rom_ok=0`, `sdram_req=0`;
  - the rdy pulse does not fill any entry.
- OFFSET=22'h3FFFF0, `rom_addr=18'h00020`: `sdram_addr=22'h000010` (wrap-around).
